// File: rtl/lsu_mem_port.sv
// -----------------------------------------------------------------------------
// lsu_mem_port
// Load/store initiator between the execute stage and data_mem. Takes one
// request at a time, checks size, alignment and address range, issues a
// single-cycle access to data_mem, captures the synchronous read data and
// holds a response until the consumer takes it.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_we, req_size,          store flag, size (01 byte, 10 half, 11 word),
//   req_signed, req_addr,      sign-extend flag for loads, byte address,
//   req_wdata                  LSB-aligned store data
//   resp_valid / resp_ready    response handshake
//   resp_rdata, resp_err       load data (0 for stores/errors), error code
//   mem_en, mem_addr,          data_mem controls: {signed, write, size[1:0]},
//   mem_wdata, mem_rdata       idle when 0; address, write data, read data
// -----------------------------------------------------------------------------
module lsu_mem_port #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic [3:0]  mem_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;
   localparam logic [1:0] ERR_SIZE  = 2'b11;

   state_t      r_state;
   logic        r_we;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic [1:0]  r_resp_err;
   logic [3:0]  r_mem_en;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;

   logic [1:0]  w_err;
   logic        w_accept;

   // Error classification of the incoming request; the first matching
   // condition wins (illegal size, then misalignment, then range).
   always_comb begin
      w_err = ERR_OK;
      if (req_size == 2'b00) begin
         w_err = ERR_SIZE;
      end else if ((req_size == 2'b10 && req_addr[0]) ||
                   (req_size == 2'b11 && req_addr[1:0] != 2'b00)) begin
         w_err = ERR_ALIGN;
      end else if (req_addr >= ADDR_LIMIT) begin
         w_err = ERR_RANGE;
      end
   end

   assign w_accept = req_valid && (r_state == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_we         <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= ERR_OK;
         r_mem_en     <= 4'b0000;
         r_mem_addr   <= 32'h0;
         r_mem_wdata  <= 32'h0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_we <= req_we;
                  if (w_err != ERR_OK) begin
                     // Faulting request: answer directly, never touch data_mem.
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= 32'h0;
                     r_resp_err   <= w_err;
                     r_state      <= ST_RESP;
                  end else begin
                     // Memory controls are registered here so they are
                     // present for exactly the ISSUE cycle.
                     r_mem_en    <= {req_signed & ~req_we, req_we, req_size};
                     r_mem_addr  <= req_addr;
                     r_mem_wdata <= req_wdata;
                     r_resp_err  <= ERR_OK;
                     r_state     <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               r_mem_en <= 4'b0000;
               if (r_we) begin
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= 32'h0;
                  r_state      <= ST_RESP;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // data_mem registered the read on the ISSUE edge; it is
               // stable on mem_rdata throughout this cycle.
               r_resp_rdata <= mem_rdata;
               r_resp_valid <= 1'b1;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_mem_en     <= 4'b0000;
               r_resp_valid <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign mem_en     = r_mem_en;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator between the execute stage and `data_mem`. Accepts one load or store request at a time over a valid/ready handshake, checks alignment and address range, drives `data_mem`'s `mem_en`/`addr`/`data_in` for exactly one cycle, captures the synchronous read data, and returns a registered response with an error code. It owns all `mem_en` encoding so the pipeline never drives `data_mem` directly.

## Interface
- `ADDR_LIMIT`, default 32'h0000_1000: first byte address outside `data_mem`. An access with `req_addr >= ADDR_LIMIT` is a range fault.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  01 = byte, 10 = half, 11 = word, 00 = illegal.
- `req_signed`  in  1  sign-extend load result; ignored for stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  2  00 = ok, 01 = misaligned, 10 = out of range, 11 = illegal size.
- `mem_en`  out  4  to `data_mem`. [3] = signed load, [2] = write, [1:0] = size; 4'b0000 = idle.
- `mem_addr`  out  32  to `data_mem` `addr`.
- `mem_wdata`  out  32  to `data_mem` `data_in`.
- `mem_rdata`  in  32  from `data_mem` `data_out`. Already sized and sign-extended by `data_mem`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready` = 1. On `req_valid`:
  - Latch all request fields.
  - Compute the error code, in priority order: size 00 → 11; misaligned (half with addr[0]=1, word with addr[1:0]≠0) → 01; `addr >= ADDR_LIMIT` → 10.
  - Error → RESP. No memory access; `mem_en` stays 0.
  - Otherwise → ISSUE.
- ISSUE: `mem_en` = {signed & ~we, we, size}, `mem_addr` = latched addr, `mem_wdata` = latched wdata. All three are registered outputs, valid this cycle only.
  - Load → WAIT.
  - Store → RESP with `resp_rdata` = 0.
- WAIT: `mem_en` = 0. Register `mem_rdata` into `resp_rdata`, then → RESP.
- RESP: `resp_valid` = 1. `resp_rdata` and `resp_err` stay stable until `resp_ready` = 1, then → IDLE.
- `mem_en` is non-zero only in ISSUE. `data_mem` therefore sees exactly one access per accepted request.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 00, `mem_en` 0000, `mem_addr` 0, `mem_wdata` 0.
- Let cycle 0 be the accept edge (req_valid & req_ready).
- Load: `mem_en` active in cycle 1, `mem_rdata` sampled at end of cycle 2, `resp_valid` in cycle 3.
- Store: `mem_en` active in cycle 1, `resp_valid` in cycle 2.
- Error: `resp_valid` in cycle 1.
- `req_ready` is 0 from cycle 1 until the cycle after the `resp_ready` handshake. There is no back-to-back overlap.
- Minimum request-to-request spacing with `resp_ready` held at 1: load 4 cycles, store 3, error 2.
- `req_ready` = (state == IDLE) and never depends combinationally on `req_valid`.
- Request inputs are ignored outside IDLE. Changing them mid-operation has no effect.
- Reset asserted during ISSUE clears `mem_en` asynchronously. A store whose rising edge has not yet occurred is not committed. After reset release the block is in IDLE and never replays the aborted request.
- Address wrap is not supported. Any address ≥ `ADDR_LIMIT`, including 32'hFFFF_FFFC, faults.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 → `mem_en` 0111 then 0011 for one cycle each. Load `resp_rdata` = 0xDEADBEEF, `resp_err` 00, `resp_valid` 3 cycles after accept.
- Store byte 0x80 to 0x21, then load byte signed → 0xFFFFFF80. Load byte unsigned → 0x00000080. `mem_en` 1001 / 0001 respectively.
- Load half at 0x23 → `resp_err` 01 in cycle 1, `mem_en` stays 0000 throughout. Store word at 0x1000 → `resp_err` 10. Request with size 00 → `resp_err` 11.
- Hold `resp_ready` = 0 for 5 cycles after a load of 0x1234 → `resp_valid` and data stable all 5 cycles, `req_ready` 0. `req_ready` returns 1 one cycle after `resp_ready` rises.
- Assert `rst_n` = 0 during ISSUE of a store of 0xCAFEF00D to 0x40 → `mem_en` drops to 0 immediately. A later load from 0x40 does not return 0xCAFEF00D.
- Back-to-back: 8 alternating store/load word pairs with `resp_ready` = 1 → one `mem_en` pulse per request, all data matches, 4-cycle load spacing, 3-cycle store spacing.
